match_controller: RTL and testbench
===================================

Name: match_controller

Overview:
Round/match sequencer for the two-player fighter. Runs on the game clock (effective_clk, one tick per frame). Watches both players' health and drives the following:
- a round-reset pulse to both player instances;
- an input freeze that gates player controls;
- round-win counters, countdown digit, round timer and match winner, for the HUD (rom/color_decider).

Parameters:
FRAMES_PER_SEC, 60, clk ticks per displayed second
COUNTDOWN_SEC, 3, pre-fight countdown length in seconds (1-3)
ROUND_TIME_SEC, 60, fight time per round in seconds (1-99)
ROUND_END_FRAMES, 120, clk ticks held in ROUND_END
ROUNDS_TO_WIN, 2, round wins needed to take the match (1-3)

Ports:
clk  in  1  game clock (effective_clk)
rst  in  1  synchronous, active-low reset
start  in  1  start/continue request, level; internally rising-edge detected
player1_health  in  3  P1 health; 0 = KO
player2_health  in  3  P2 health; 0 = KO
game_state  out  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_END
players_rst  out  1  one-cycle round-reset pulse to both players
freeze  out  1  1 = player inputs ignored
countdown  out  2  countdown digit shown during COUNTDOWN
round_time  out  7  seconds remaining in round
p1_rounds  out  2  P1 round wins
p2_rounds  out  2  P2 round wins
round_result  out  2  last round: 0 none/draw, 1 P1, 2 P2
winner  out  2  0 none, 1 P1, 2 P2; valid in MATCH_END

Behaviour:
- All outputs registered. Reset is synchronous, active-low and wins over everything, including mid-round.
- Reset values: game_state=IDLE, freeze=1, players_rst=0, countdown=0, round_time=ROUND_TIME_SEC, p1_rounds=p2_rounds=0, round_result=0, winner=0. Frame counter=0. start edge-detect history=1, so a start held through reset does not trigger.
- Internal frame counter frm, 0..FRAMES_PER_SEC-1. Cleared on every state entry. "Second tick" = cycle where frm==FRAMES_PER_SEC-1.
- IDLE: freeze=1.
  - start rising edge -> players_rst=1 for exactly that next cycle; clear rounds/round_result/winner; countdown=COUNTDOWN_SEC; round_time=ROUND_TIME_SEC; go COUNTDOWN.
- COUNTDOWN: freeze=1.
  - Each second tick: if countdown==1 -> countdown=0, go FIGHT; else countdown-1.
  - Health is ignored here.
- FIGHT: freeze=0.
  - KO/timeout checks are evaluated every cycle.
  - Priority:
    1. both health==0 same cycle -> draw;
    2. player1_health==0 -> P2 wins;
    3. player2_health==0 -> P1 wins;
    4. second tick with round_time==1 -> round_time=0, higher health wins, equal = draw;
    5. otherwise, on second tick round_time-1.
  - A round decision sets round_result, increments the winner's count (saturating at 3), and goes ROUND_END.
  - A draw sets round_result=0 with no increment.
- ROUND_END: freeze=1; hold for ROUND_END_FRAMES cycles, then:
  - if p1_rounds==ROUNDS_TO_WIN or p2_rounds==ROUNDS_TO_WIN -> winner set accordingly, go MATCH_END;
  - else -> players_rst pulse, countdown=COUNTDOWN_SEC, round_time=ROUND_TIME_SEC, go COUNTDOWN.
- MATCH_END: freeze=1; all counters hold.
  - start rising edge -> same actions as the IDLE start (new match).
- Latency: state change is visible one cycle after the deciding condition. players_rst is asserted in the first cycle of COUNTDOWN.
- start edges outside IDLE/MATCH_END are ignored.
- Unknown game_state encodings recover to IDLE.

Optional Feature:
MATCH_CTRL_PAUSE_EN
- Defined: adds input port pause (1 bit, level).
  - While pause=1 in COUNTDOWN or FIGHT: freeze=1; frm, countdown and round_time hold; KO checks are suppressed.
  - Release resumes exactly where it stopped.
  - Pause has no effect in other states.
- Undefined: no pause port; behaviour is as above.

Test Plan:
Bench parameters unless noted: FRAMES_PER_SEC=4, COUNTDOWN_SEC=3, ROUND_TIME_SEC=5, ROUND_END_FRAMES=8, ROUNDS_TO_WIN=2.
1. Reset with start held high -> game_state=0, freeze=1, no transition until start falls and rises again. Then players_rst high exactly 1 cycle, countdown 3,2,1 at 4-cycle spacing, FIGHT entered 12 cycles after start.
2. FIGHT, player2_health driven to 0 at cycle 5 -> ROUND_END next cycle, round_result=1, p1_rounds=1. After 8 cycles: players_rst pulse, COUNTDOWN with round_time=5.
3. Round 2 with healths 4 vs 2 and no KO -> round_time 5->0 over 20 cycles, then round_result=1, p1_rounds=2. After ROUND_END: MATCH_END, winner=1, freeze=1.
4. Both healths go to 0 on the same cycle -> round_result=0, both counts unchanged, new COUNTDOWN after ROUND_END.
5. rst low mid-FIGHT with p2_rounds=1 -> next cycle: IDLE, all counts 0, freeze=1, round_time=5.
6. With MATCH_CTRL_PAUSE_EN: pause=1 for 10 cycles at round_time=3, with player1_health=0 during the pause -> round_time stays 3, no ROUND_END. After release, KO is detected the next cycle.

Source files
------------

// File: rtl/match_controller.sv
// rtl/match_controller.sv - round/match sequencer: countdown, fight timer, KO/timeout scoring, match winner
// Optional MATCH_CTRL_PAUSE_EN adds a pause input that holds COUNTDOWN/FIGHT in place.
module match_controller #(
  parameter int FRAMES_PER_SEC   = 60,
  parameter int COUNTDOWN_SEC    = 3,
  parameter int ROUND_TIME_SEC   = 60,
  parameter int ROUND_END_FRAMES = 120,
  parameter int ROUNDS_TO_WIN    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef MATCH_CTRL_PAUSE_EN
  input  logic       pause,
`endif
  input  logic [2:0] player1_health,
  input  logic [2:0] player2_health,
  output logic [2:0] game_state,
  output logic       players_rst,
  output logic       freeze,
  output logic [1:0] countdown,
  output logic [6:0] round_time,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [1:0] round_result,
  output logic [1:0] winner
);
  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int HW = (ROUND_END_FRAMES > 1) ? $clog2(ROUND_END_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST  = FW'(FRAMES_PER_SEC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ROUND_END_FRAMES - 1);
  localparam logic [1:0]    CD_INIT   = 2'(COUNTDOWN_SEC);
  localparam logic [6:0]    RT_INIT   = 7'(ROUND_TIME_SEC);
  localparam logic [1:0]    WIN_CNT   = 2'(ROUNDS_TO_WIN);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    FIGHT     = 3'd2,
    ROUND_END = 3'd3,
    MATCH_END = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] frm_q, frm_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          start_q;
  logic          prst_q, prst_d;
  logic          freeze_q, freeze_d;
  logic [1:0]    cd_q, cd_d;
  logic [6:0]    rt_q, rt_d;
  logic [1:0]    p1_q, p1_d;
  logic [1:0]    p2_q, p2_d;
  logic [1:0]    res_q, res_d;
  logic [1:0]    win_q, win_d;
  logic          paused, start_rise, sec_tick, p1_ko, p2_ko;
  logic          decide;
  logic [1:0]    res;

`ifdef MATCH_CTRL_PAUSE_EN
  assign paused = pause && ((state_q == COUNTDOWN) || (state_q == FIGHT));
`else
  assign paused = 1'b0;
`endif

  assign start_rise = start & ~start_q;
  assign sec_tick   = (frm_q == FRM_LAST);
  assign p1_ko      = (player1_health == 3'd0);
  assign p2_ko      = (player2_health == 3'd0);

  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    hold_d  = hold_q;
    prst_d  = 1'b0;
    cd_d    = cd_q;
    rt_d    = rt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    res_d   = res_q;
    win_d   = win_q;
    decide  = 1'b0;
    res     = 2'd0;

    case (state_q)
      IDLE, MATCH_END: begin
        if (start_rise) begin
          state_d = COUNTDOWN;
          prst_d  = 1'b1;
          p1_d    = 2'd0;
          p2_d    = 2'd0;
          res_d   = 2'd0;
          win_d   = 2'd0;
          cd_d    = CD_INIT;
          rt_d    = RT_INIT;
        end
      end
      COUNTDOWN: begin
        if (!paused) begin
          frm_d = sec_tick ? '0 : frm_q + 1'b1;
          if (sec_tick) begin
            if (cd_q <= 2'd1) begin
              cd_d    = 2'd0;
              state_d = FIGHT;
            end else begin
              cd_d = cd_q - 2'd1;
            end
          end
        end
      end
      FIGHT: begin
        if (!paused) begin
          frm_d = sec_tick ? '0 : frm_q + 1'b1;
          // KO outranks the clock; a double KO is a draw
          if (p1_ko || p2_ko) begin
            decide = 1'b1;
            res    = (p1_ko && p2_ko) ? 2'd0 : (p1_ko ? 2'd2 : 2'd1);
          end else if (sec_tick && (rt_q <= 7'd1)) begin
            decide = 1'b1;
            rt_d   = 7'd0;
            if (player1_health > player2_health) begin
              res = 2'd1;
            end else if (player1_health < player2_health) begin
              res = 2'd2;
            end
          end else if (sec_tick) begin
            rt_d = rt_q - 7'd1;
          end
        end
        if (decide) begin
          state_d = ROUND_END;
          res_d   = res;
          if ((res == 2'd1) && (p1_q != 2'd3)) p1_d = p1_q + 2'd1;
          if ((res == 2'd2) && (p2_q != 2'd3)) p2_d = p2_q + 2'd1;
        end
      end
      ROUND_END: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          if (p1_q == WIN_CNT) begin
            win_d   = 2'd1;
            state_d = MATCH_END;
          end else if (p2_q == WIN_CNT) begin
            win_d   = 2'd2;
            state_d = MATCH_END;
          end else begin
            prst_d  = 1'b1;
            cd_d    = CD_INIT;
            rt_d    = RT_INIT;
            state_d = COUNTDOWN;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // every state starts its frame/hold timing from zero
    if (state_d != state_q) begin
      frm_d  = '0;
      hold_d = '0;
    end
    freeze_d = (state_d != FIGHT) | paused;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      frm_q    <= '0;
      hold_q   <= '0;
      start_q  <= 1'b1;
      prst_q   <= 1'b0;
      freeze_q <= 1'b1;
      cd_q     <= 2'd0;
      rt_q     <= RT_INIT;
      p1_q     <= 2'd0;
      p2_q     <= 2'd0;
      res_q    <= 2'd0;
      win_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      frm_q    <= frm_d;
      hold_q   <= hold_d;
      start_q  <= start;
      prst_q   <= prst_d;
      freeze_q <= freeze_d;
      cd_q     <= cd_d;
      rt_q     <= rt_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      res_q    <= res_d;
      win_q    <= win_d;
    end
  end

  assign game_state   = state_q;
  assign players_rst  = prst_q;
  assign freeze       = freeze_q;
  assign countdown    = cd_q;
  assign round_time   = rt_q;
  assign p1_rounds    = p1_q;
  assign p2_rounds    = p2_q;
  assign round_result = res_q;
  assign winner       = win_q;
endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - scoreboard bench for match_controller: timeline model vs observed output changes
module tb_match_controller;
  localparam int FPS = 4, CDS = 3, RTS = 5, REF = 8, RTW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b1;
  logic [2:0] h1 = 3'd7, h2 = 3'd7;
`ifdef MATCH_CTRL_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [2:0] game_state;
  logic       players_rst, freeze;
  logic [1:0] countdown, p1_rounds, p2_rounds, round_result, winner;
  logic [6:0] round_time;

  match_controller #(
    .FRAMES_PER_SEC(FPS), .COUNTDOWN_SEC(CDS), .ROUND_TIME_SEC(RTS),
    .ROUND_END_FRAMES(REF), .ROUNDS_TO_WIN(RTW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef MATCH_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .player1_health(h1), .player2_health(h2),
    .game_state(game_state), .players_rst(players_rst), .freeze(freeze),
    .countdown(countdown), .round_time(round_time), .p1_rounds(p1_rounds),
    .p2_rounds(p2_rounds), .round_result(round_result), .winner(winner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  st;
    logic [1:0]  cd;
    logic [6:0]  rt;
    logic [1:0]  p1, p2, res, win;
    logic        frz, prst;
  } rec_t;

  rec_t exp_q[$];
  int   compared = 0, mismatched = 0;
  int   m_p1 = 0, m_p2 = 0, m_res = 0, m_win = 0;
  int   f_next = 0, t_ready = 0, t_last = 0;
  bit   m_over = 1'b1, mon_en = 1'b0;

  function automatic logic [20:0] key(rec_t r);
    return {r.st, r.cd, r.rt, r.p1, r.p2, r.res, r.win, r.frz};
  endfunction

  // expected output snapshot at the cycle it must first become visible
  function automatic void push(int c, int st, int cd, int rt, int frz, int prst);
    rec_t r;
    r.cyc = 32'(c);  r.st = 3'(st);  r.cd = 2'(cd);  r.rt = 7'(rt);
    r.p1 = 2'(m_p1); r.p2 = 2'(m_p2); r.res = 2'(m_res); r.win = 2'(m_win);
    r.frz = 1'(frz); r.prst = 1'(prst);
    exp_q.push_back(r);
    if (c > t_last) t_last = c;
  endfunction

  // countdown entered at cycle e; returns the cycle FIGHT becomes visible
  function automatic int countdown_seq(int e);
    push(e, 1, CDS, RTS, 1, 1);
    for (int i = 1; i < CDS; i++) push(e + i * FPS, 1, CDS - i, RTS, 1, 0);
    push(e + CDS * FPS, 2, 0, RTS, 0, 0);
    return e + CDS * FPS;
  endfunction

  rec_t prev, cur, e;
  bit   primed = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!primed) begin
        prev = '{cyc: 32'd0, st: 3'd0, cd: 2'd0, rt: 7'(RTS), p1: 2'd0, p2: 2'd0,
                 res: 2'd0, win: 2'd0, frz: 1'b1, prst: 1'b0};
        primed = 1'b1;
      end
      cur = '{cyc: 32'(cyc), st: game_state, cd: countdown, rt: round_time, p1: p1_rounds,
              p2: p2_rounds, res: round_result, win: winner, frz: freeze, prst: players_rst};
      if (key(cur) !== key(prev)) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_change cyc=%0d st=%0d cd=%0d rt=%0d p1=%0d p2=%0d res=%0d win=%0d frz=%0d required no change",
                   cur.cyc, cur.st, cur.cd, cur.rt, cur.p1, cur.p2, cur.res, cur.win, cur.frz);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            mismatched++;
            $display("FAIL event got cyc=%0d st=%0d cd=%0d rt=%0d p1=%0d p2=%0d res=%0d win=%0d frz=%0d prst=%0d required cyc=%0d st=%0d cd=%0d rt=%0d p1=%0d p2=%0d res=%0d win=%0d frz=%0d prst=%0d",
                     cur.cyc, cur.st, cur.cd, cur.rt, cur.p1, cur.p2, cur.res, cur.win, cur.frz, cur.prst,
                     e.cyc, e.st, e.cd, e.rt, e.p1, e.p2, e.res, e.win, e.frz, e.prst);
          end
        end
      end else begin
        if (players_rst !== 1'b0) begin
          compared++;
          mismatched++;
          $display("FAIL stray_players_rst cyc=%0d got=%0d required=0", cyc, players_rst);
        end
        if ((exp_q.size() > 0) && (int'(exp_q[0].cyc) < cyc)) begin
          e = exp_q.pop_front();
          compared++;
          mismatched++;
          $display("FAIL missing_event cyc=%0d got st=%0d rt=%0d required st=%0d cd=%0d rt=%0d by cyc=%0d",
                   cyc, game_state, round_time, e.st, e.cd, e.rt, e.cyc);
        end
      end
      prev = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int got, int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic start_match();
    while (cyc < t_ready + 1) begin
      start = 1'b0;
      h1 = 3'($urandom_range(0, 7));
      h2 = 3'($urandom_range(0, 7));
      tick();
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    m_p1 = 0; m_p2 = 0; m_res = 0; m_win = 0; m_over = 1'b0;
    f_next = countdown_seq(cyc + 1);
    tick();
    start = 1'b0;
  endtask

  // mode: 0 P1 KO, 1 P2 KO, 2 double KO, 3 timeout, 4 reset mid-fight, 5 paused P1 KO
  task automatic run_round(input int mode, input int kko, input int fh1, input int fh2);
    int rt, res, rts, ee;
    bit ts, dec;
    while (cyc < f_next) begin
      h1 = 3'($urandom_range(0, 7));
      h2 = 3'($urandom_range(0, 7));
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      rt = RTS - k / FPS;
      ts = (k % FPS) == (FPS - 1);
      h1 = ((mode == 0 || mode == 2 || mode == 5) && k >= kko) ? 3'd0 : 3'(fh1);
      h2 = ((mode == 1 || mode == 2) && k >= kko) ? 3'd0 : 3'(fh2);
      if (mode == 4 && k == kko) begin
        rst = 1'b0;
        start = 1'b1;
        m_p1 = 0; m_p2 = 0; m_res = 0; m_win = 0;
        push(cyc + 1, 0, 0, RTS, 1, 0);
        tick();
        tick();
        rst = 1'b1;
        m_over = 1'b1;
        t_ready = cyc;
        return;
      end
`ifdef MATCH_CTRL_PAUSE_EN
      if (mode == 5 && k == kko) begin
        pause = 1'b1;
        push(cyc + 1, 2, 0, rt, 1, 0);
        repeat (10) tick();
        pause = 1'b0;
      end
`endif
      dec = 1'b0;
      rts = rt;
      res = 0;
      if (h1 == 3'd0 || h2 == 3'd0) begin
        dec = 1'b1;
        res = (h1 == 3'd0 && h2 == 3'd0) ? 0 : ((h1 == 3'd0) ? 2 : 1);
      end else if (ts && rt == 1) begin
        dec = 1'b1;
        rts = 0;
        res = (fh1 > fh2) ? 1 : ((fh1 < fh2) ? 2 : 0);
      end else if (ts) begin
        push(cyc + 1, 2, 0, rt - 1, 0, 0);
      end
      if (dec) begin
        if (res == 1 && m_p1 < 3) m_p1++;
        if (res == 2 && m_p2 < 3) m_p2++;
        m_res = res;
        push(cyc + 1, 3, 0, rts, 1, 0);
        ee = cyc + 1 + REF;
        if (m_p1 == RTW || m_p2 == RTW) begin
          m_win = (m_p1 == RTW) ? 1 : 2;
          push(ee, 4, 0, rts, 1, 0);
          m_over = 1'b1;
          t_ready = ee;
        end else begin
          f_next = countdown_seq(ee);
        end
        tick();
        return;
      end
      tick();
    end
  endtask

  initial begin
    int rounds, r, mode;
    repeat (3) tick();
    check("rst_game_state", int'(game_state), 0);
    check("rst_freeze", int'(freeze), 1);
    check("rst_players_rst", int'(players_rst), 0);
    check("rst_countdown", int'(countdown), 0);
    check("rst_round_time", int'(round_time), RTS);
    check("rst_p1_rounds", int'(p1_rounds), 0);
    check("rst_p2_rounds", int'(p2_rounds), 0);
    check("rst_round_result", int'(round_result), 0);
    check("rst_winner", int'(winner), 0);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (6) tick();
    check("held_start_state", int'(game_state), 0);
    check("held_start_freeze", int'(freeze), 1);
    t_ready = cyc;

    start_match();
    run_round(1, 5, 6, 6);
    run_round(3, 0, 4, 2);

    start_match();
    run_round(2, 7, 5, 3);
`ifdef MATCH_CTRL_PAUSE_EN
    run_round(5, 9, 6, 6);
`else
    run_round(0, 3, 6, 6);
`endif
    run_round(4, 10, 6, 6);

    for (int m = 0; m < 15; m++) begin
      start_match();
      rounds = 0;
      while (!m_over) begin
        r = $urandom_range(0, 9);
        mode = (r < 3) ? 0 : (r < 6) ? 1 : (r == 6) ? 2 : (r < 9) ? 3 : 4;
        if (rounds >= 6) mode = 4;
        run_round(mode, $urandom_range(0, 19), $urandom_range(1, 7), $urandom_range(1, 7));
        rounds++;
      end
    end

    while (cyc <= t_last + 3) tick();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_events got=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    mismatched++;
    $display("FAIL watchdog cyc=%0d required bench completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1);
  end
endmodule
